// File: rtl/pmod_enc_decoder.sv
// PmodENC front end: per-signal synchronizer + debouncer, quadrature detent
// decoder with a wrapping position counter, and single-cycle event pulses.

module pmod_enc_debounce #(
    parameter int   DEBOUNCE_CYCLES = 200000,
    parameter logic RST_VAL         = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= {2{RST_VAL}};
            level <= RST_VAL;
            cnt   <= '0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module pmod_enc_decoder #(
    parameter int DEBOUNCE_CYCLES = 200000,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                   sysclk,
    input  logic                   sysreset,
    input  logic                   enc_a,
    input  logic                   enc_b,
    input  logic                   enc_btn,
    input  logic                   enc_sw,
    input  logic                   clear_count,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   step_valid,
    output logic                   step_dir,
    output logic                   btn_level,
    output logic                   btn_press,
    output logic                   sw_level
);
    localparam int NUM_LANES = 4;
    // Lane order {sw, btn, b, a}; A/B idle high at the detent rest position.
    localparam logic [NUM_LANES-1:0] RST_LVL = 4'b0011;

    typedef enum logic [2:0] {IDLE, CW1, CW2, CW3, CCW1, CCW2, CCW3, RESYNC} state_t;

    logic [NUM_LANES-1:0] raw_bus;
    logic [NUM_LANES-1:0] lvl_bus;
    logic [1:0]           ab;
    state_t               state;
    logic                 step_inc;
    logic                 step_dec;
    logic                 btn_q;

    assign raw_bus = {enc_sw, enc_btn, enc_b, enc_a};

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        pmod_enc_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RST_VAL        (RST_LVL[i])
        ) u_db (
            .clk  (sysclk),
            .rst  (sysreset),
            .raw  (raw_bus[i]),
            .level(lvl_bus[i])
        );
    end

    assign ab        = {lvl_bus[0], lvl_bus[1]};
    assign btn_level = lvl_bus[2];
    assign sw_level  = lvl_bus[3];

    // A detent completes only on the final return to 11 from the third phase.
    assign step_inc = (state == CW3)  && (ab == 2'b11);
    assign step_dec = (state == CCW3) && (ab == 2'b11);

    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            state      <= IDLE;
            count      <= '0;
            step_valid <= 1'b0;
            step_dir   <= 1'b0;
            btn_q      <= 1'b0;
            btn_press  <= 1'b0;
        end else begin
            case (state)
                IDLE:   case (ab) 2'b01: state <= CW1;  2'b10: state <= CCW1; 2'b00: state <= RESYNC; default: ; endcase
                CW1:    case (ab) 2'b00: state <= CW2;  2'b11: state <= IDLE; 2'b10: state <= RESYNC; default: ; endcase
                CW2:    case (ab) 2'b10: state <= CW3;  2'b01: state <= CW1;  2'b11: state <= RESYNC; default: ; endcase
                CW3:    case (ab) 2'b11: state <= IDLE; 2'b00: state <= CW2;  2'b01: state <= RESYNC; default: ; endcase
                CCW1:   case (ab) 2'b00: state <= CCW2; 2'b11: state <= IDLE; 2'b01: state <= RESYNC; default: ; endcase
                CCW2:   case (ab) 2'b01: state <= CCW3; 2'b10: state <= CCW1; 2'b11: state <= RESYNC; default: ; endcase
                CCW3:   case (ab) 2'b11: state <= IDLE; 2'b00: state <= CCW2; 2'b10: state <= RESYNC; default: ; endcase
                RESYNC: if (ab == 2'b11) state <= IDLE;
                default: state <= IDLE;
            endcase

            step_valid <= step_inc | step_dec;
            if (step_inc | step_dec) step_dir <= step_inc;

            // Clear has priority over a coincident step; the pulse still fires.
            if (clear_count)   count <= '0;
            else if (step_inc) count <= count + 1'b1;
            else if (step_dec) count <= count - 1'b1;

            btn_q     <= btn_level;
            btn_press <= btn_level & ~btn_q;
        end
    end
endmodule

// File: tb/tb_pmod_enc_decoder.sv
// Bench for pmod_enc_decoder: directed detent/glitch/clear/reset scenarios, then
// random stimulus, all checked cycle-by-cycle against a phase-offset model.

module tb_pmod_enc_decoder;
    localparam int DC = 4;
    localparam int W  = 4;

    logic         sysclk = 1'b0;
    logic         sysreset, enc_a, enc_b, enc_btn, enc_sw, clear_count;
    logic [W-1:0] count;
    logic         step_valid, step_dir, btn_level, btn_press, sw_level;

    always #5 sysclk = ~sysclk;

    pmod_enc_decoder #(.DEBOUNCE_CYCLES(DC), .COUNT_WIDTH(W)) dut (
        .sysclk     (sysclk),
        .sysreset   (sysreset),
        .enc_a      (enc_a),
        .enc_b      (enc_b),
        .enc_btn    (enc_btn),
        .enc_sw     (enc_sw),
        .clear_count(clear_count),
        .count      (count),
        .step_valid (step_valid),
        .step_dir   (step_dir),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .sw_level   (sw_level)
    );

    int errors = 0;
    int checks = 0;
    int sv_cnt = 0;
    int bp_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Position of an AB code along the clockwise cycle 11->01->00->10.
    function automatic int phase(input logic [1:0] ab);
        case (ab)
            2'b11:   return 0;
            2'b01:   return 1;
            2'b00:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] ph2ab(input int ph);
        case (ph)
            0:       return 2'b11;
            1:       return 2'b01;
            2:       return 2'b00;
            default: return 2'b10;
        endcase
    endfunction

    // Model: lanes {sw, btn, b, a}. Debounced level flips once the last DC
    // synchronized samples all disagree with it. Rotation is tracked as a
    // signed phase offset from the detent; +/-4 is a full step, a jump of two
    // phases loses sync until 11 is seen again.
    logic [3:0]    m_s1, m_s2, m_d;
    logic [DC-1:0] m_hist [4];
    logic [1:0]    m_qab;
    int            m_off;
    bit            m_lost;
    logic [W-1:0]  m_count;
    logic          m_sv, m_sd, m_bq, m_bp;
    bit            m_ready = 0;

    always @(posedge sysclk) begin : model
        logic [3:0]    raw, nd;
        logic [DC-1:0] h [4];
        logic [1:0]    cur;
        int            dlt, off;
        bit            lost, stp;
        logic          dir;
        raw = {enc_sw, enc_btn, enc_b, enc_a};
        if (sysreset) begin
            m_s1 <= 4'b0011; m_s2 <= 4'b0011; m_d <= 4'b0011;
            m_hist[0] <= '1; m_hist[1] <= '1; m_hist[2] <= '0; m_hist[3] <= '0;
            m_qab <= 2'b11; m_off <= 0; m_lost <= 0; m_count <= '0;
            m_sv <= 0; m_sd <= 0; m_bq <= 0; m_bp <= 0; m_ready <= 1;
        end else begin
            nd = m_d;
            for (int i = 0; i < 4; i++) begin
                h[i] = {m_hist[i][DC-2:0], m_s2[i]};
                if (h[i] == {DC{~m_d[i]}}) nd[i] = ~m_d[i];
            end
            cur = {m_d[0], m_d[1]};
            stp = 0; dir = 0; off = m_off; lost = m_lost;
            if (lost) begin
                if (cur == 2'b11) begin lost = 0; off = 0; end
            end else if (cur != m_qab) begin
                dlt = (phase(cur) - phase(m_qab) + 4) % 4;
                if (dlt == 2) lost = 1;
                else begin
                    off += (dlt == 1) ? 1 : -1;
                    if (off == 4 || off == -4) begin stp = 1; dir = (off > 0); off = 0; end
                end
            end
            m_qab <= cur; m_off <= off; m_lost <= lost;
            m_sv <= stp;
            if (stp) m_sd <= dir;
            if (clear_count) m_count <= '0;
            else if (stp)    m_count <= dir ? m_count + 1'b1 : m_count - 1'b1;
            m_bp <= m_d[2] & ~m_bq;
            m_bq <= m_d[2];
            m_s1 <= raw; m_s2 <= m_s1; m_d <= nd;
            for (int i = 0; i < 4; i++) m_hist[i] <= h[i];
        end
    end

    always @(negedge sysclk) begin
        if (m_ready) begin
            check("count", count, m_count);
            check("step_valid", step_valid, m_sv);
            check("step_dir", step_dir, m_sd);
            check("btn_level", btn_level, m_d[2]);
            check("btn_press", btn_press, m_bp);
            check("sw_level", sw_level, m_d[3]);
            if (step_valid === 1'b1) sv_cnt++;
            if (btn_press === 1'b1) bp_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge sysclk); #2; end
    endtask

    task automatic set_ab(input logic a, input logic b);
        enc_a = a; enc_b = b; tick(10);
    endtask

    task automatic cw();
        set_ab(0, 1); set_ab(0, 0); set_ab(1, 0); set_ab(1, 1);
    endtask

    task automatic ccw();
        set_ab(1, 0); set_ab(0, 0); set_ab(0, 1); set_ab(1, 1);
    endtask

    initial begin : stim
        int sv0, bp0, r, ph;
        sysreset = 1; enc_a = 1; enc_b = 1; enc_btn = 0; enc_sw = 0; clear_count = 0;
        tick(3);
        check("rst_count", count, 0);
        check("rst_step_valid", step_valid, 0);
        check("rst_step_dir", step_dir, 0);
        check("rst_btn_level", btn_level, 0);
        check("rst_btn_press", btn_press, 0);
        check("rst_sw_level", sw_level, 0);
        sysreset = 0;
        tick(10);

        // Three clockwise detents.
        sv0 = sv_cnt;
        cw();
        check("cw1_count", count, 1);
        check("cw1_dir", step_dir, 1);
        check("cw1_pulses", sv_cnt - sv0, 1);
        cw(); cw();
        check("cw3_count", count, 3);
        check("cw3_pulses", sv_cnt - sv0, 3);

        // Counter-clockwise from zero wraps down, then back up.
        clear_count = 1; tick(1); clear_count = 0; tick(2);
        check("clear_count", count, 0);
        ccw();
        check("ccw_wrap_count", count, 15);
        check("ccw_dir", step_dir, 0);
        cw();
        check("cw_wrap_count", count, 0);

        // Reversed partial detent and illegal jump produce no step.
        sv0 = sv_cnt;
        set_ab(0, 1); set_ab(1, 1);
        check("partial_pulses", sv_cnt - sv0, 0);
        set_ab(0, 0); set_ab(1, 1);
        check("resync_pulses", sv_cnt - sv0, 0);
        check("resync_count", count, 0);
        cw();
        check("after_resync_count", count, 1);

        // Short glitch on A is filtered.
        sv0 = sv_cnt;
        enc_a = 0; tick(3); enc_a = 1; tick(12);
        check("glitch_pulses", sv_cnt - sv0, 0);
        check("glitch_count", count, 1);

        // Button latency: level rises exactly 2 + DC cycles after the raw edge.
        bp0 = bp_cnt;
        enc_btn = 1; tick(5);
        check("btn_before", btn_level, 0);
        tick(1);
        check("btn_after", btn_level, 1);
        enc_btn = 0; tick(12);
        check("btn_press_once", bp_cnt - bp0, 1);
        check("btn_released", btn_level, 0);
        enc_sw = 1; tick(6);
        check("sw_level_up", sw_level, 1);
        check("sw_no_press", bp_cnt - bp0, 1);
        enc_sw = 0; tick(8);

        // Clear coinciding with a completing step.
        cw(); cw(); cw(); cw();
        check("pre_clear_count", count, 5);
        set_ab(0, 1); set_ab(0, 0); set_ab(1, 0);
        enc_a = 1; enc_b = 1; tick(6);
        clear_count = 1; tick(1); clear_count = 0;
        check("clr_step_count", count, 0);
        check("clr_step_valid", step_valid, 1);
        check("clr_step_dir", step_dir, 1);
        tick(10);

        // Reset in the middle of a detent discards it.
        repeat (7) cw();
        check("pre_reset_count", count, 7);
        set_ab(0, 1); set_ab(0, 0);
        sysreset = 1; tick(1);
        check("midrst_count", count, 0);
        check("midrst_dir", step_dir, 0);
        check("midrst_valid", step_valid, 0);
        sysreset = 0;
        sv0 = sv_cnt;
        tick(10);
        set_ab(1, 0); set_ab(1, 1);
        check("tail_pulses", sv_cnt - sv0, 0);
        check("tail_count", count, 0);

        // Random walk with glitches, illegal jumps, clears and resets.
        ph = 0;
        for (int it = 0; it < 600; it++) begin
            r = $urandom_range(0, 99);
            if (r < 45)      ph = (ph + 1) % 4;
            else if (r < 70) ph = (ph + 3) % 4;
            else if (r < 75) ph = (ph + 2) % 4;
            else if (r < 87) enc_btn = ~enc_btn;
            else if (r < 93) enc_sw = ~enc_sw;
            {enc_a, enc_b} = ph2ab(ph);
            clear_count = ($urandom_range(0, 19) == 0);
            sysreset = ($urandom_range(0, 59) == 0);
            tick(1);
            clear_count = 0; sysreset = 0;
            tick($urandom_range(0, 11));
        end
        tick(20);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
